iir_biquad_mc: RTL and testbench

Multi-channel, runtime-configurable second-order IIR section in IEEE-754 single precision. It time-multiplexes one `float_multiplier` and one `float_adder` across `CH_NUM` independent channels, with per-channel history kept in registers. It sits between the ADC sample deframer and the downstream filter chain, and replaces fixed-coefficient, single-channel filter instances. Sections cascade for higher orders.

---
 rtl/iir_biquad_mc.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 tb/tb_iir_biquad_mc.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/iir_biquad_mc.sv
// Multi-channel second-order IIR section in single-precision float.
// One shared multiplier and one shared adder are stepped through the five terms by a handshake FSM.

module float_multiplier (
  input  logic        i_CLK,
  input  logic        i_RST,
  input  logic [31:0] i_A,
  input  logic [31:0] i_B,
  input  logic        i_AB_STB,
  output logic        o_AB_ACK,
  output logic [31:0] o_Z,
  output logic        o_Z_STB,
  input  logic        i_Z_ACK
);
  typedef enum logic [1:0] {U_GET, U_CALC, U_PUT} unit_state_e;

  unit_state_e state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d, z_q, z_d;
  logic        ack_q, ack_d, stb_q, stb_d;

  // Normal operands only; a zero exponent is treated as zero, rounding is nearest-even.
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic              sgn;
    logic [47:0]       p;
    logic signed [9:0] e;
    logic [22:0]       m;
    logic              g, st;
    logic [23:0]       mr;
    sgn = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {sgn, 31'd0};
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
    if (p[47]) begin
      m  = p[46:24];
      g  = p[23];
      st = |p[22:0];
      e  = e + 10'sd1;
    end else begin
      m  = p[45:23];
      g  = p[22];
      st = |p[21:0];
    end
    mr = {1'b0, m} + {23'd0, g & (st | m[0])};
    if (mr[23]) e = e + 10'sd1;
    if (e <= 10'sd0) return {sgn, 31'd0};
    if (e >= 10'sd255) return {sgn, 8'hff, 23'd0};
    return {sgn, e[7:0], mr[22:0]};
  endfunction

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state_q <= U_GET;
      a_q     <= '0;
      b_q     <= '0;
      z_q     <= '0;
      ack_q   <= 1'b0;
      stb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      z_q     <= z_d;
      ack_q   <= ack_d;
      stb_q   <= stb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    z_d     = z_q;
    ack_d   = ack_q;
    stb_d   = stb_q;
    case (state_q)
      U_GET: begin
        ack_d = 1'b1;
        if (i_AB_STB && ack_q) begin
          a_d     = i_A;
          b_d     = i_B;
          ack_d   = 1'b0;
          state_d = U_CALC;
        end
      end
      U_CALC: begin
        z_d     = fp_mul(a_q, b_q);
        stb_d   = 1'b1;
        state_d = U_PUT;
      end
      U_PUT: begin
        if (i_Z_ACK && stb_q) begin
          stb_d   = 1'b0;
          state_d = U_GET;
        end
      end
      default: state_d = U_GET;
    endcase
  end

  assign o_AB_ACK = ack_q;
  assign o_Z      = z_q;
  assign o_Z_STB  = stb_q;
endmodule

module float_adder (
  input  logic        i_CLK,
  input  logic        i_RST,
  input  logic [31:0] i_A,
  input  logic [31:0] i_B,
  input  logic        i_AB_STB,
  output logic        o_AB_ACK,
  output logic [31:0] o_Z,
  output logic        o_Z_STB,
  input  logic        i_Z_ACK
);
  typedef enum logic [1:0] {U_GET, U_CALC, U_PUT} unit_state_e;

  unit_state_e state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d, z_q, z_d;
  logic        ack_q, ack_d, stb_q, stb_d;

  // Larger magnitude sets the sign; three guard bits feed nearest-even rounding.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0]       l, s;
    logic [26:0]       ml, ms;
    logic [27:0]       sum;
    logic [7:0]        d;
    logic signed [9:0] e;
    logic              sticky;
    logic [23:0]       mr;
    if (a[30:23] == 8'd0 && b[30:23] == 8'd0) return {a[31] & b[31], 31'd0};
    if (a[30:23] == 8'd0) return b;
    if (b[30:23] == 8'd0) return a;
    if (a[30:0] >= b[30:0]) begin
      l = a;
      s = b;
    end else begin
      l = b;
      s = a;
    end
    d  = l[30:23] - s[30:23];
    ml = {1'b1, l[22:0], 3'b000};
    ms = {1'b1, s[22:0], 3'b000};
    if (d > 8'd26) begin
      ms = 27'd1;
    end else begin
      sticky = |(ms & ((27'd1 << d) - 27'd1));
      ms     = (ms >> d) | {26'd0, sticky};
    end
    e = $signed({2'b00, l[30:23]});
    if (l[31] == s[31]) sum = {1'b0, ml} + {1'b0, ms};
    else                sum = {1'b0, ml} - {1'b0, ms};
    if (sum == 28'd0) return 32'd0;
    if (sum[27]) begin
      sum = {1'b0, sum[27:2], sum[1] | sum[0]};
      e   = e + 10'sd1;
    end
    for (int i = 0; i < 26; i++) begin
      if (!sum[26]) begin
        sum = {sum[26:0], 1'b0};
        e   = e - 10'sd1;
      end
    end
    if (e <= 10'sd0) return {l[31], 31'd0};
    mr = {1'b0, sum[25:3]} + {23'd0, sum[2] & (sum[1] | sum[0] | sum[3])};
    if (mr[23]) e = e + 10'sd1;
    if (e >= 10'sd255) return {l[31], 8'hff, 23'd0};
    return {l[31], e[7:0], mr[22:0]};
  endfunction

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state_q <= U_GET;
      a_q     <= '0;
      b_q     <= '0;
      z_q     <= '0;
      ack_q   <= 1'b0;
      stb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      z_q     <= z_d;
      ack_q   <= ack_d;
      stb_q   <= stb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    z_d     = z_q;
    ack_d   = ack_q;
    stb_d   = stb_q;
    case (state_q)
      U_GET: begin
        ack_d = 1'b1;
        if (i_AB_STB && ack_q) begin
          a_d     = i_A;
          b_d     = i_B;
          ack_d   = 1'b0;
          state_d = U_CALC;
        end
      end
      U_CALC: begin
        z_d     = fp_add(a_q, b_q);
        stb_d   = 1'b1;
        state_d = U_PUT;
      end
      U_PUT: begin
        if (i_Z_ACK && stb_q) begin
          stb_d   = 1'b0;
          state_d = U_GET;
        end
      end
      default: state_d = U_GET;
    endcase
  end

  assign o_AB_ACK = ack_q;
  assign o_Z      = z_q;
  assign o_Z_STB  = stb_q;
endmodule

// Handshakes: a transfer happens on any clock edge where the producer's valid/strobe and the
// consumer's ready/ack are both high; the producer holds data stable until that edge.
module iir_biquad_mc #(
  parameter int          CH_NUM  = 3,
  parameter int          CH_W    = 2,
  parameter logic [31:0] B0_INIT = 32'h3f800000,
  parameter logic [31:0] B1_INIT = 32'h00000000,
  parameter logic [31:0] B2_INIT = 32'h00000000,
  parameter logic [31:0] A1_INIT = 32'h00000000,
  parameter logic [31:0] A2_INIT = 32'h00000000
) (
  input  logic            i_CLK,
  input  logic            i_RST,
  input  logic [31:0]     i_X_DATA,
  input  logic [CH_W-1:0] i_X_CH,
  input  logic            i_X_BYPASS,
  input  logic            i_X_DATA_VALID,
  output logic            o_X_DATA_READY,
  output logic [31:0]     o_Y_DATA,
  output logic [CH_W-1:0] o_Y_CH,
  output logic            o_Y_DATA_VALID,
  input  logic            i_Y_ACK,
  input  logic            i_COEF_WE,
  input  logic [2:0]      i_COEF_ADDR,
  input  logic [31:0]     i_COEF_DATA,
  input  logic            i_STATE_CLR,
  output logic [2:0]      o_DBG_STATE
);
  typedef enum logic [2:0] {IDLE, MUL_REQ, MUL_WAIT, ADD_REQ, ADD_WAIT, UPDATE, OUT} state_e;

  localparam logic [CH_W:0] CH_LIM = (CH_W+1)'(CH_NUM);

  state_e          state_q, state_d;
  logic [2:0]      k_q, k_d;
  logic [31:0]     x_q, x_d, acc_q, acc_d, prod_q, prod_d, y_q, y_d;
  logic [CH_W-1:0] ch_q, ch_d, y_ch_q, y_ch_d;
  logic            y_vld_q, y_vld_d;
  logic [31:0]     b0_q, b0_d, b1_q, b1_d, b2_q, b2_d, a1_q, a1_d, a2_q, a2_d;
  logic [31:0]     x1_q [CH_NUM];
  logic [31:0]     x1_d [CH_NUM];
  logic [31:0]     x2_q [CH_NUM];
  logic [31:0]     x2_d [CH_NUM];
  logic [31:0]     y1_q [CH_NUM];
  logic [31:0]     y1_d [CH_NUM];
  logic [31:0]     y2_q [CH_NUM];
  logic [31:0]     y2_d [CH_NUM];

  logic [31:0] mul_a, mul_b, mul_z, add_z;
  logic        mul_stb, mul_ack, mul_z_stb, mul_z_ack;
  logic        add_stb, add_ack, add_z_stb, add_z_ack;
  logic        accept;

  float_multiplier u_mul (
    .i_CLK(i_CLK), .i_RST(i_RST), .i_A(mul_a), .i_B(mul_b), .i_AB_STB(mul_stb),
    .o_AB_ACK(mul_ack), .o_Z(mul_z), .o_Z_STB(mul_z_stb), .i_Z_ACK(mul_z_ack)
  );

  float_adder u_add (
    .i_CLK(i_CLK), .i_RST(i_RST), .i_A(acc_q), .i_B(prod_q), .i_AB_STB(add_stb),
    .o_AB_ACK(add_ack), .o_Z(add_z), .o_Z_STB(add_z_stb), .i_Z_ACK(add_z_ack)
  );

  assign mul_stb        = (state_q == MUL_REQ);
  assign mul_z_ack      = (state_q == MUL_WAIT) && mul_z_stb;
  assign add_stb        = (state_q == ADD_REQ);
  assign add_z_ack      = (state_q == ADD_WAIT) && add_z_stb;
  assign o_X_DATA_READY = (state_q == IDLE);
  assign o_Y_DATA       = y_q;
  assign o_Y_CH         = y_ch_q;
  assign o_Y_DATA_VALID = y_vld_q;
  assign o_DBG_STATE    = state_q;
  assign accept         = i_X_DATA_VALID && !i_STATE_CLR;

  // Feedback terms subtract by flipping the coefficient sign into the product.
  always_comb begin
    mul_a = b0_q;
    mul_b = x_q;
    case (k_q)
      3'd1: begin mul_a = b1_q;                  mul_b = x1_q[ch_q]; end
      3'd2: begin mul_a = b2_q;                  mul_b = x2_q[ch_q]; end
      3'd3: begin mul_a = {~a1_q[31], a1_q[30:0]}; mul_b = y1_q[ch_q]; end
      3'd4: begin mul_a = {~a2_q[31], a2_q[30:0]}; mul_b = y2_q[ch_q]; end
      default: ;
    endcase
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state_q <= IDLE;
      k_q     <= '0;
      x_q     <= '0;
      ch_q    <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
      y_q     <= '0;
      y_ch_q  <= '0;
      y_vld_q <= 1'b0;
      b0_q    <= B0_INIT;
      b1_q    <= B1_INIT;
      b2_q    <= B2_INIT;
      a1_q    <= A1_INIT;
      a2_q    <= A2_INIT;
      for (int c = 0; c < CH_NUM; c++) begin
        x1_q[c] <= '0;
        x2_q[c] <= '0;
        y1_q[c] <= '0;
        y2_q[c] <= '0;
      end
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      x_q     <= x_d;
      ch_q    <= ch_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      y_q     <= y_d;
      y_ch_q  <= y_ch_d;
      y_vld_q <= y_vld_d;
      b0_q    <= b0_d;
      b1_q    <= b1_d;
      b2_q    <= b2_d;
      a1_q    <= a1_d;
      a2_q    <= a2_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      y1_q    <= y1_d;
      y2_q    <= y2_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    x_d     = x_q;
    ch_d    = ch_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    y_d     = y_q;
    y_ch_d  = y_ch_q;
    y_vld_d = y_vld_q;
    b0_d    = b0_q;
    b1_d    = b1_q;
    b2_d    = b2_q;
    a1_d    = a1_q;
    a2_d    = a2_q;
    x1_d    = x1_q;
    x2_d    = x2_q;
    y1_d    = y1_q;
    y2_d    = y2_q;
    case (state_q)
      IDLE: begin
        if (i_STATE_CLR) begin
          for (int c = 0; c < CH_NUM; c++) begin
            x1_d[c] = '0;
            x2_d[c] = '0;
            y1_d[c] = '0;
            y2_d[c] = '0;
          end
        end else if (i_X_DATA_VALID) begin
          x_d  = i_X_DATA;
          ch_d = i_X_CH;
          if (i_X_BYPASS || {1'b0, i_X_CH} >= CH_LIM) begin
            y_d     = i_X_DATA;
            y_ch_d  = i_X_CH;
            y_vld_d = 1'b1;
            state_d = OUT;
          end else begin
            k_d     = 3'd0;
            state_d = MUL_REQ;
          end
        end
        // Coefficients only change while no sample is being taken in.
        if (i_COEF_WE && !accept) begin
          case (i_COEF_ADDR)
            3'd0: b0_d = i_COEF_DATA;
            3'd1: b1_d = i_COEF_DATA;
            3'd2: b2_d = i_COEF_DATA;
            3'd3: a1_d = i_COEF_DATA;
            3'd4: a2_d = i_COEF_DATA;
            default: ;
          endcase
        end
      end
      MUL_REQ: if (mul_ack) state_d = MUL_WAIT;
      MUL_WAIT: begin
        if (mul_z_stb) begin
          prod_d = mul_z;
          if (k_q == 3'd0) begin
            acc_d   = mul_z;
            k_d     = 3'd1;
            state_d = MUL_REQ;
          end else begin
            state_d = ADD_REQ;
          end
        end
      end
      ADD_REQ: if (add_ack) state_d = ADD_WAIT;
      ADD_WAIT: begin
        if (add_z_stb) begin
          acc_d = add_z;
          if (k_q < 3'd4) begin
            k_d     = k_q + 3'd1;
            state_d = MUL_REQ;
          end else begin
            state_d = UPDATE;
          end
        end
      end
      UPDATE: begin
        x2_d[ch_q] = x1_q[ch_q];
        x1_d[ch_q] = x_q;
        y2_d[ch_q] = y1_q[ch_q];
        y1_d[ch_q] = acc_q;
        y_d        = acc_q;
        y_ch_d     = ch_q;
        y_vld_d    = 1'b1;
        state_d    = OUT;
      end
      OUT: begin
        if (y_vld_q && i_Y_ACK) begin
          y_vld_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_iir_biquad_mc.sv
// Directed bench for iir_biquad_mc: hand-computed float results for passthrough, gain,
// recursion, channel isolation, bypass/range and control corners.

module tb_iir_biquad_mc;
  localparam int CH_W = 2;

  localparam logic [31:0] F05  = 32'h3f000000;
  localparam logic [31:0] F1   = 32'h3f800000;
  localparam logic [31:0] F15  = 32'h3fc00000;
  localparam logic [31:0] F175 = 32'h3fe00000;
  localparam logic [31:0] F2   = 32'h40000000;
  localparam logic [31:0] F3   = 32'h40400000;
  localparam logic [31:0] F5   = 32'h40a00000;
  localparam logic [31:0] F10  = 32'h41200000;
  localparam logic [31:0] FM05 = 32'hbf000000;

  logic            clk = 1'b0;
  logic            rst;
  logic [31:0]     x_data;
  logic [CH_W-1:0] x_ch;
  logic            x_bypass, x_valid, x_ready;
  logic [31:0]     y_data;
  logic [CH_W-1:0] y_ch;
  logic            y_valid, y_ack;
  logic            coef_we;
  logic [2:0]      coef_addr;
  logic [31:0]     coef_data;
  logic            state_clr;
  logic [2:0]      dbg_state;

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0]     exp_q[$];
  logic [CH_W-1:0] exp_ch_q[$];

  iir_biquad_mc #(.CH_NUM(3), .CH_W(CH_W)) dut (
    .i_CLK(clk), .i_RST(rst),
    .i_X_DATA(x_data), .i_X_CH(x_ch), .i_X_BYPASS(x_bypass),
    .i_X_DATA_VALID(x_valid), .o_X_DATA_READY(x_ready),
    .o_Y_DATA(y_data), .o_Y_CH(y_ch), .o_Y_DATA_VALID(y_valid), .i_Y_ACK(y_ack),
    .i_COEF_WE(coef_we), .i_COEF_ADDR(coef_addr), .i_COEF_DATA(coef_data),
    .i_STATE_CLR(state_clr), .o_DBG_STATE(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic coef_wr(input logic [2:0] addr, input logic [31:0] data);
    coef_we   = 1'b1;
    coef_addr = addr;
    coef_data = data;
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic clr();
    state_clr = 1'b1;
    @(negedge clk);
    state_clr = 1'b0;
  endtask

  // One sample through the block; optional coefficient poke while busy and ack stall.
  task automatic send(input logic [CH_W-1:0] ch, input logic [31:0] x, input logic byp,
                      input logic [31:0] exp_y, input bit poke, input int hold);
    int          n;
    bit          changed;
    logic [31:0]     e_y;
    logic [CH_W-1:0] e_ch;
    exp_q.push_back(exp_y);
    exp_ch_q.push_back(ch);
    n = 0;
    while (!x_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_send", 32'(x_ready), 32'd1);
    x_data   = x;
    x_ch     = ch;
    x_bypass = byp;
    x_valid  = 1'b1;
    @(negedge clk);
    x_valid  = 1'b0;
    x_bypass = 1'b0;
    chk("ready_drop", 32'(x_ready), 32'd0);
    if (byp || ch >= 2'd3) chk("bypass_latency", 32'(y_valid), 32'd1);
    if (poke) begin
      coef_wr(3'd0, F2);
    end
    n = 0;
    while (!y_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("y_valid_seen", 32'(y_valid), 32'd1);
    changed = 1'b0;
    e_y = y_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (y_data !== e_y || y_valid !== 1'b1) changed = 1'b1;
    end
    if (hold > 0) chk("hold_stable", 32'(changed), 32'd0);
    e_y  = exp_q.pop_front();
    e_ch = exp_ch_q.pop_front();
    chk("y_data", y_data, e_y);
    chk("y_ch", 32'(y_ch), 32'(e_ch));
    y_ack = 1'b1;
    @(negedge clk);
    y_ack = 1'b0;
    chk("valid_clear", 32'(y_valid), 32'd0);
    chk("ready_return", 32'(x_ready), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(x_ready), 32'd1);
    chk({tag, "_y"}, y_data, 32'd0);
    chk({tag, "_ych"}, 32'(y_ch), 32'd0);
    chk({tag, "_valid"}, 32'(y_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] seq [3];
    int n;
    seq[0] = F1;
    seq[1] = F15;
    seq[2] = F175;
    rst = 1'b1;
    x_data = '0; x_ch = '0; x_bypass = 1'b0; x_valid = 1'b0; y_ack = 1'b0;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0; state_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    send(2'd0, F3, 1'b0, F3, 1'b0, 0);

    coef_wr(3'd0, F05);
    send(2'd0, F2, 1'b0, F1, 1'b0, 0);

    coef_wr(3'd0, F1);
    coef_wr(3'd3, FM05);
    clr();
    send(2'd1, F1, 1'b0, F1, 1'b0, 0);
    send(2'd1, F1, 1'b0, F15, 1'b0, 0);
    send(2'd1, F1, 1'b0, F175, 1'b0, 0);

    clr();
    for (int i = 0; i < 3; i++) begin
      send(2'd0, F1, 1'b0, seq[i], 1'b0, 0);
      send(2'd1, F1, 1'b0, seq[i], 1'b0, 0);
    end
    clr();
    send(2'd2, F1, 1'b0, F1, 1'b0, 0);

    clr();
    send(2'd0, F1, 1'b0, F1, 1'b0, 0);
    send(2'd0, F5, 1'b1, F5, 1'b0, 0);
    send(2'd3, F10, 1'b0, F10, 1'b0, 0);
    send(2'd1, F5, 1'b1, F5, 1'b0, 0);
    send(2'd0, F1, 1'b0, F15, 1'b0, 0);
    send(2'd1, F1, 1'b0, F1, 1'b0, 0);

    clr();
    send(2'd2, F1, 1'b0, F1, 1'b1, 0);
    send(2'd2, F1, 1'b0, F15, 1'b0, 0);
    send(2'd2, F1, 1'b0, F175, 1'b0, 20);

    clr();
    send(2'd0, F1, 1'b0, F1, 1'b0, 0);
    x_data  = F1;
    x_ch    = 2'd0;
    x_valid = 1'b1;
    @(negedge clk);
    x_valid = 1'b0;
    n = 0;
    while (dbg_state != 3'd2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("mid_multiply_reached", 32'(dbg_state), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("mid_reset");
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_idle_valid", 32'(y_valid), 32'd0);
    coef_wr(3'd3, FM05);
    send(2'd0, F1, 1'b0, F1, 1'b0, 0);
    send(2'd0, F1, 1'b0, F15, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
